// File: rtl/le_sender.sv
// Transmit-side Link Element endpoint: a staging FIFO feeds an output register
// that presents one token per cycle on O_FTk and re-presents it after a downstream nack.
package le_pkg;
  parameter int unsigned WIDTH_DATA = 8;

  typedef struct packed {
    logic                  v;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module le_sender
  import le_pkg::*;
#(
  parameter int unsigned DEPTH_FIFO = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned WIDTH_NUM  = $clog2(DEPTH_FIFO)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  FTk_t                 I_FTk,
  output BTk_t                 O_BTk,
  output FTk_t                 O_FTk,
  input  BTk_t                 I_BTk,
  input  logic                 I_Flush,
  output logic                 O_Empty,
  output logic                 O_Full,
  output logic [WIDTH_NUM:0]   O_Num,
  output logic [7:0]           O_Retry,
  output logic                 O_Err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                 state;
  logic [WIDTH_DATA-1:0]  mem [DEPTH_FIFO];
  logic [WIDTH_NUM:0]     wr_ptr;
  logic [WIDTH_NUM:0]     rd_ptr;
  logic [WIDTH_DATA-1:0]  r_out;
  logic [CNT_W-1:0]       hold_cnt;
  logic                   prev_nack;
  logic                   nack;
  logic                   push;
  logic                   pop;

  assign nack    = I_BTk.n;
  assign O_Num   = wr_ptr - rd_ptr;
  assign O_Full  = (O_Num == (WIDTH_NUM+1)'(DEPTH_FIFO));
  assign O_Empty = (O_Num == '0);
  assign push    = I_FTk.v & ~O_Full;
  // A pop only ever happens when the current R_Out (if any) is being accepted.
  assign pop     = ~O_Empty & ~nack & ((state == IDLE) | (state == SEND));

  always_comb begin
    O_BTk   = I_BTk;
    O_BTk.n = O_Full;
  end

  always_comb begin
    O_FTk = '0;
    if (state == SEND && !I_Flush) begin
      O_FTk.v = 1'b1;
      O_FTk.d = r_out;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !I_Flush) mem[wr_ptr[WIDTH_NUM-1:0]] <= I_FTk.d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      r_out     <= '0;
      hold_cnt  <= '0;
      prev_nack <= 1'b0;
      O_Retry   <= '0;
      O_Err     <= 1'b0;
    end else if (I_Flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      r_out     <= '0;
      hold_cnt  <= '0;
      prev_nack <= nack;
      O_Retry   <= '0;
      O_Err     <= 1'b0;
    end else begin
      prev_nack <= nack;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        r_out  <= mem[rd_ptr[WIDTH_NUM-1:0]];
      end
      case (state)
        IDLE: if (pop) state <= SEND;
        SEND: begin
          if (nack) begin
            if (O_Retry != '1) O_Retry <= O_Retry + 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
          end else if (!pop) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // Counter parks at TIMEOUT-1 so the stuck flag cannot be missed by wrap.
          if (hold_cnt == CNT_W'(TIMEOUT - 1)) O_Err <= 1'b1;
          else hold_cnt <= hold_cnt + 1'b1;
          if (!nack && !prev_nack) state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
